fir_sym_tap_sequencer: RTL and testbench
========================================

// Module: fir_sym_tap_sequencer
// PURPOSE
//  Upstream control/data stage for the pre-adder MACC primitive in the symmetric FIR.
//  Buffers input samples in a circular delay line and, per accepted sample, issues NTAPS/2 symmetric tap pairs.
//  Each pair is driven as PREADD1/PREADD2 with its coefficient on MULTIPLIER.
//  Captures the accumulated PRODUCT, rounds, saturates and emits one filtered sample.
// PARAMETERS
//  NTAPS      32  filter length; even, >=4
//  DATA_W     16  signed sample width; <=24 so the 25-bit pre-add cannot overflow
//  COEF_W     18  signed coefficient width; <=18
//  MACC_LAT   3   cycles from tap issue (sequencer output regs) to PRODUCT reflecting that tap
//  OUT_SHIFT  15  arithmetic right shift applied to PRODUCT
//  OUT_W      16  signed output width
// PORTS
//  CLK              in   1   clock
//  RST              in   1   synchronous active-high reset
//  in_valid         in   1   input sample valid
//  in_ready         out  1   sequencer accepts a sample
//  in_data          in   DATA_W  signed input sample
//  out_valid        out  1   filtered sample valid
//  out_ready        in   1   consumer accepts out_data
//  out_data         out  OUT_W  rounded, saturated filter output
//  busy             out  1   state != IDLE
//  macc_ce          out  1   MACC clock enable
//  macc_load        out  1   MACC accumulator load
//  macc_load_data   out  48  MACC load value
//  macc_carryin     out  1   MACC carry-in
//  macc_preadd1     out  25  newer sample of pair, sign-extended
//  macc_preadd2     out  25  older sample of pair, sign-extended
//  macc_multiplier  out  18  coefficient, sign-extended
//  macc_product     in   48  MACC PRODUCT
// BEHAVIOUR
//  - Single clock domain (CLK); synchronous active-high RST.
//  - FSM: INIT -> IDLE -> RUN -> DRAIN -> OUT -> IDLE. Let H = NTAPS/2.
//  - RST (any state, including mid-RUN/DRAIN/OUT) forces INIT, discarding in-flight work.
//  - Reset values: in_ready=0, out_valid=0, out_data=0, busy=1.
//  - Reset values: all macc_* outputs 0 except macc_ce=1.
//  - INIT: clears delay line, one address per cycle for NTAPS cycles, then IDLE.
//  - IDLE: in_ready=1. Accept (in_valid&in_ready) at cycle 0: write sample at wr_ptr, go RUN.
//  - RUN: cycles 1..H issue tap k=0..H-1 from registered outputs:
//    - preadd1 = x[n-k]; preadd2 = x[n-(NTAPS-1-k)]; multiplier = coef[k].
//    - Delay-line addresses computed modulo NTAPS; wr_ptr wraps NTAPS-1 -> 0.
//  - k=0: macc_load=1, macc_load_data = ROUND (1<<(OUT_SHIFT-1), or 0 if OUT_SHIFT=0). Else macc_load=0.
//  - macc_carryin = 0 always.
//  - macc_ce = 1 always.
//  - Outside RUN, preadd1/preadd2/multiplier are driven 0 so the accumulator sees zero products.
//  - DRAIN: wait MACC_LAT cycles. Sample macc_product at cycle H+MACC_LAT.
//  - out_data = sat_OUT_W(product >>> OUT_SHIFT).
//  - Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  - out_valid rises cycle H+MACC_LAT+1 (default 20) in state OUT.
//  - OUT: out_valid and out_data are held stable until out_ready. Handshake cycle -> IDLE.
//  - in_ready=0 while out_valid=1.
//  - out_ready asserted in the same cycle out_valid rises completes the handshake that cycle.
//  - in_valid while not ready is ignored. in_data is sampled only on the accept cycle.
// CONFIGURATION
//  FIR_COEF_RELOAD_EN defined:
//    - Adds ports coef_we(1), coef_addr($clog2(H)), coef_wdata(COEF_W): runtime coefficient RAM.
//    - Writes are honoured only in IDLE; ignored elsewhere.
//    - RST reloads fir_pkg::COEF_INIT during INIT.
//  FIR_COEF_RELOAD_EN undefined:
//    - Ports absent; coefficients are the constant fir_pkg::COEF_INIT.
// STRUCTURE
//  - fir_pkg holds:
//    - fsm state enum;
//    - MACC width constants (25/18/48);
//    - COEF_INIT[H] table;
//    - sat/sign-extend functions.
//  - Sub-module fir_sample_ring: NTAPS-deep circular buffer.
//    - One write port, two read ports (newer/older), clear port for INIT.
// TESTING
//  Bench pairs the sequencer with a behavioural MACC model of latency MACC_LAT.
//  1 Reset: RST high 2 cycles -> outputs at reset values; in_ready=1 after 32 INIT cycles.
//  2 Impulse, OUT_SHIFT=0: in 1 then 31 zeros -> out m = COEF_INIT[min(m,31-m)].
//  3 Full-scale: all in=32767, COEF_INIT all 131071, OUT_SHIFT=15 -> out saturates to 32767.
//    - Negative full-scale input -> out saturates to -32768.
//  4 Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0.
//    - Single handshake, then IDLE.
//  5 Wrap/mid-op reset: stream 70 samples, check wr_ptr wrap against golden model.
//    - Assert RST during RUN -> out_valid=0 next cycle, INIT re-entered, buffer zero.
//  6 FIR_COEF_RELOAD_EN: write coef[3]=-5 in IDLE, impulse -> out 3 = -5.
//    - A write during RUN is ignored.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types, MACC port widths, the default coefficient table and the
// saturation/sign-extension helpers for the symmetric FIR tap sequencer.
package fir_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_OUT
  } fir_state_e;

  localparam int PRE_W = 25;
  localparam int MUL_W = 18;
  localparam int P_W   = 48;

  // Index 0 weights the outermost pair (newest with oldest); the last entry is the centre pair.
  localparam int COEF_INIT_LEN = 16;
  localparam logic signed [MUL_W-1:0] COEF_INIT [COEF_INIT_LEN] = '{
    18'sd100,   -18'sd200,  18'sd300,   -18'sd400,
    18'sd500,   -18'sd600,  18'sd800,   -18'sd1000,
    18'sd1300,  -18'sd1700, 18'sd2200,  -18'sd3000,
    18'sd4200,  -18'sd6500, 18'sd13000, 18'sd20000
  };

  function automatic logic signed [MUL_W-1:0] coef_init(input int unsigned k);
    return (k < COEF_INIT_LEN) ? COEF_INIT[k] : '0;
  endfunction

  function automatic logic signed [PRE_W-1:0] sext_pre(input logic signed [23:0] v);
    return PRE_W'(v);
  endfunction

  // Clamp v to the range of a w-bit signed number.
  function automatic logic signed [P_W-1:0] sat(input logic signed [P_W-1:0] v,
                                                input int unsigned w);
    logic signed [P_W-1:0] hi;
    hi = $signed((P_W'(1) << (w - 1)) - P_W'(1));
    if (v > hi) return hi;
    if (v < ~hi) return ~hi;
    return v;
  endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample store: one write port, a clear port used while initialising,
// and two asynchronous read ports for the newer/older member of a tap pair.
module fir_sample_ring #(
  parameter int DEPTH = 32,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] clr_addr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_new,
  input  logic [AW-1:0] raddr_old,
  output logic [W-1:0]  rdata_new,
  output logic [W-1:0]  rdata_old
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      mem[clr_addr] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_new = mem[raddr_new];
  assign rdata_old = mem[raddr_old];

endmodule

// File: rtl/fir_sym_tap_sequencer.sv
// Symmetric FIR tap sequencer feeding a pre-adder MACC; FIR_COEF_RELOAD_EN adds
// a runtime-writable coefficient RAM (writes honoured only while idle).
module fir_sym_tap_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS     = 32,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 18,
  parameter int MACC_LAT  = 3,
  parameter int OUT_SHIFT = 15,
  parameter int OUT_W     = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     busy,
  output logic                     macc_ce,
  output logic                     macc_load,
  output logic [P_W-1:0]           macc_load_data,
  output logic                     macc_carryin,
  output logic signed [PRE_W-1:0]  macc_preadd1,
  output logic signed [PRE_W-1:0]  macc_preadd2,
  output logic signed [MUL_W-1:0]  macc_multiplier,
  input  logic signed [P_W-1:0]    macc_product
`ifdef FIR_COEF_RELOAD_EN
  ,
  input  logic                        coef_we,
  input  logic [$clog2(NTAPS/2)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0]    coef_wdata
`endif
);

  localparam int H     = NTAPS / 2;
  localparam int AW    = $clog2(NTAPS);
  localparam int CNT_W = $clog2(NTAPS + MACC_LAT + 1);
  localparam logic [P_W-1:0] ROUND =
    (OUT_SHIFT > 0) ? (P_W'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;

  fir_state_e state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [AW-1:0] wr_ptr_reg, cur_ptr_reg;
  logic accept, issue;
  logic [AW-1:0] issue_k, base_ptr, addr_new, addr_old;
  logic signed [DATA_W-1:0] rd_new, rd_old, newer;
  logic signed [COEF_W-1:0] coef_rd;

  // Reduce a sum below 2*NTAPS into the ring's address range.
  function automatic logic [AW-1:0] wrap(input logic [AW:0] s);
    return (s >= (AW+1)'(NTAPS)) ? AW'(s - (AW+1)'(NTAPS)) : AW'(s);
  endfunction

  assign in_ready     = (state_reg == ST_IDLE);
  assign out_valid    = (state_reg == ST_OUT);
  assign busy         = (state_reg != ST_IDLE);
  assign macc_ce      = 1'b1;
  assign macc_carryin = 1'b0;
  assign accept       = in_ready && in_valid;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_INIT: begin
        if (cnt_reg == CNT_W'(NTAPS - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      end
      ST_RUN: begin
        if (cnt_reg == CNT_W'(H - 1)) begin
          state_next = ST_DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_reg == CNT_W'(MACC_LAT - 1)) begin
          state_next = ST_OUT;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Tap 0 is registered on the accept edge itself, so the newest sample bypasses the ring.
  always_comb begin
    issue    = accept || (state_reg == ST_RUN && cnt_reg != CNT_W'(H - 1));
    issue_k  = accept ? '0 : AW'(cnt_reg + CNT_W'(1));
    base_ptr = accept ? wr_ptr_reg : cur_ptr_reg;
    addr_new = wrap({1'b0, base_ptr} + (AW+1)'(NTAPS) - {1'b0, issue_k});
    addr_old = wrap({1'b0, base_ptr} + (AW+1)'(1) + {1'b0, issue_k});
    newer    = accept ? in_data : rd_new;
  end

  fir_sample_ring #(
    .DEPTH (NTAPS),
    .W     (DATA_W)
  ) u_ring (
    .clk       (CLK),
    .clr       (state_reg == ST_INIT),
    .clr_addr  (cnt_reg[AW-1:0]),
    .we        (accept),
    .waddr     (wr_ptr_reg),
    .wdata     (in_data),
    .raddr_new (addr_new),
    .raddr_old (addr_old),
    .rdata_new (rd_new),
    .rdata_old (rd_old)
  );

`ifdef FIR_COEF_RELOAD_EN
  localparam int KW = $clog2(H);
  logic signed [COEF_W-1:0] coef_mem [H];

  always_ff @(posedge CLK) begin
    if (state_reg == ST_INIT) begin
      if (cnt_reg < CNT_W'(H)) coef_mem[cnt_reg[KW-1:0]] <= COEF_W'(coef_init(int'(cnt_reg)));
    end else if (state_reg == ST_IDLE && coef_we) begin
      coef_mem[coef_addr] <= coef_wdata;
    end
  end

  assign coef_rd = coef_mem[issue_k[KW-1:0]];
`else
  assign coef_rd = COEF_W'(coef_init(int'(issue_k)));
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      macc_load       <= 1'b0;
      macc_load_data  <= '0;
      macc_preadd1    <= '0;
      macc_preadd2    <= '0;
      macc_multiplier <= '0;
      wr_ptr_reg      <= '0;
      cur_ptr_reg     <= '0;
      out_data        <= '0;
    end else begin
      macc_load      <= accept;
      macc_load_data <= accept ? ROUND : '0;
      // Zero operands between taps keep the accumulator unchanged while draining.
      if (issue) begin
        macc_preadd1    <= sext_pre(24'(newer));
        macc_preadd2    <= sext_pre(24'(rd_old));
        macc_multiplier <= MUL_W'(coef_rd);
      end else begin
        macc_preadd1    <= '0;
        macc_preadd2    <= '0;
        macc_multiplier <= '0;
      end
      if (accept) begin
        cur_ptr_reg <= wr_ptr_reg;
        wr_ptr_reg  <= (wr_ptr_reg == AW'(NTAPS - 1)) ? '0 : wr_ptr_reg + AW'(1);
      end
      if (state_reg == ST_DRAIN && cnt_reg == CNT_W'(MACC_LAT - 1)) begin
        out_data <= OUT_W'(sat(macc_product >>> OUT_SHIFT, OUT_W));
      end
    end
  end

endmodule

// File: tb/tb_fir_sym_tap_sequencer.sv
// Bench for fir_sym_tap_sequencer: behavioural MACC plus a direct-form FIR reference;
// the coefficient-reload steps run only when FIR_COEF_RELOAD_EN is defined.
module tb_fir_sym_tap_sequencer;
  import fir_pkg::*;

  localparam int NTAPS     = 32;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 18;
  localparam int MACC_LAT  = 3;
  localparam int OUT_SHIFT = 15;
  localparam int OUT_W     = 16;
  localparam int H         = NTAPS / 2;
  localparam longint RND   = longint'(1) << (OUT_SHIFT - 1);
  localparam longint OMAX  = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint OMIN  = -(longint'(1) << (OUT_W - 1));

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                     RST;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     busy;
  logic                     macc_ce;
  logic                     macc_load;
  logic [47:0]              macc_load_data;
  logic                     macc_carryin;
  logic signed [24:0]       macc_preadd1;
  logic signed [24:0]       macc_preadd2;
  logic signed [17:0]       macc_multiplier;
  logic signed [47:0]       macc_product;
`ifdef FIR_COEF_RELOAD_EN
  logic                     coef_we = 1'b0;
  logic [$clog2(H)-1:0]     coef_addr = '0;
  logic signed [COEF_W-1:0] coef_wdata = '0;
`endif

  int errors = 0;
  int checks = 0;
  int txn = 0;
  int hist[$];
  longint coef_m [H];

  fir_sym_tap_sequencer #(
    .NTAPS(NTAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
    .MACC_LAT(MACC_LAT), .OUT_SHIFT(OUT_SHIFT), .OUT_W(OUT_W)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .busy            (busy),
    .macc_ce         (macc_ce),
    .macc_load       (macc_load),
    .macc_load_data  (macc_load_data),
    .macc_carryin    (macc_carryin),
    .macc_preadd1    (macc_preadd1),
    .macc_preadd2    (macc_preadd2),
    .macc_multiplier (macc_multiplier),
    .macc_product    (macc_product)
`ifdef FIR_COEF_RELOAD_EN
    ,
    .coef_we         (coef_we),
    .coef_addr       (coef_addr),
    .coef_wdata      (coef_wdata)
`endif
  );

  // Pre-adder MACC: P = (load ? C : P) + (A + D) * B, visible MACC_LAT cycles after its operands.
  logic signed [47:0] pipe [MACC_LAT] = '{default: '0};
  always @(posedge CLK) begin
    longint a;
    if (macc_ce) begin
      a = macc_load ? longint'(macc_load_data) : longint'(pipe[0]);
      a = a + (longint'(macc_preadd1) + longint'(macc_preadd2)) * longint'(macc_multiplier)
            + longint'(macc_carryin);
      pipe[0] <= 48'(a);
      for (int i = 1; i < MACC_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign macc_product = pipe[MACC_LAT-1];

  // Direct-form reference: y[n] = sum_m h[m] x[n-m] with h mirrored about the centre.
  function automatic longint expect_out();
    longint y = 0;
    longint r;
    for (int m = 0; m < NTAPS; m++) begin
      if (m < hist.size()) y += coef_m[(m < NTAPS - 1 - m) ? m : NTAPS - 1 - m] * hist[m];
    end
    r = (y + RND) >>> OUT_SHIFT;
    if (r > OMAX) r = OMAX;
    if (r < OMIN) r = OMIN;
    return r;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic run_txn(input int x, input int hold, input bit probe, output longint got);
    int lat;
    int guard;
    longint expv;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    check("ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_data  = DATA_W'(x);
    hist.push_front(x);
    if (hist.size() > NTAPS) void'(hist.pop_back());
    expv = expect_out();
    @(negedge CLK);
    in_data = DATA_W'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (lat == 3) in_valid = 1'b0;
`ifdef FIR_COEF_RELOAD_EN
      coef_we    = probe && (lat == 2);
      coef_addr  = 3;
      coef_wdata = 18'sd999;
`endif
      @(negedge CLK);
      lat++;
    end
    in_valid = 1'b0;
`ifdef FIR_COEF_RELOAD_EN
    coef_we = 1'b0;
`endif
    got = longint'(out_data);
    check("latency", lat, H + MACC_LAT + 1);
    check("out_data", out_data, expv);
    check("in_ready_while_valid", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, expv);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check("post_handshake_valid", out_valid, 0);
    check("post_handshake_idle", in_ready, 1);
    $display("txn %0d in=%0d out=%0d exp=%0d lat=%0d hold=%0d probe=%0d",
             txn, x, got, expv, lat, hold, probe);
    txn++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_macc_ce"}, macc_ce, 1);
    check({tag, "_macc_load"}, macc_load, 0);
    check({tag, "_load_data"}, macc_load_data, 0);
    check({tag, "_carryin"}, macc_carryin, 0);
    check({tag, "_preadd1"}, macc_preadd1, 0);
    check({tag, "_preadd2"}, macc_preadd2, 0);
    check({tag, "_multiplier"}, macc_multiplier, 0);
  endtask

  initial begin
    longint got;
    RST = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    for (int i = 0; i < H; i++) coef_m[i] = longint'(COEF_INIT[i]);

    // Reset and initialisation length
    @(negedge CLK);
    check_reset_outputs("rst");
    @(negedge CLK);
    RST = 1'b0;
    repeat (NTAPS - 1) @(negedge CLK);
    check("init_not_ready", in_ready, 0);
    @(negedge CLK);
    check("init_done_ready", in_ready, 1);
    check("init_done_busy", busy, 0);

    // Impulse response walks the mirrored coefficient table
    run_txn(32767, 0, 1'b0, got);
    for (int i = 0; i < NTAPS + 1; i++) run_txn(0, 0, 1'b0, got);

    // Full-scale positive and negative inputs saturate
    for (int i = 0; i < NTAPS; i++) run_txn(32767, 0, 1'b0, got);
    check("fullscale_pos_sat", got, 32767);
    for (int i = 0; i < NTAPS; i++) run_txn(-32768, 0, 1'b0, got);
    check("fullscale_neg_sat", got, -32768);

    // Backpressure
    run_txn(int'($urandom_range(0, 65535)) - 32768, 10, 1'b0, got);

    // Long random stream wraps the write pointer twice
    for (int i = 0; i < 70; i++)
      run_txn(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 2)), 1'b0, got);

    // Reset in the middle of a run
    in_valid = 1'b1;
    in_data  = 16'sd12345;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (4) @(negedge CLK);
    check("midrun_busy", busy, 1);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outputs("midrst");
    RST = 1'b0;
    repeat (NTAPS - 1) @(negedge CLK);
    check("reinit_not_ready", in_ready, 0);
    @(negedge CLK);
    check("reinit_ready", in_ready, 1);
    hist.delete();
    run_txn(1000, 0, 1'b0, got);
    for (int i = 0; i < NTAPS; i++) run_txn(0, 0, 1'b0, got);

`ifdef FIR_COEF_RELOAD_EN
    // Idle write is honoured, a write during RUN is not
    coef_we    = 1'b1;
    coef_addr  = 3;
    coef_wdata = -18'sd5;
    @(negedge CLK);
    coef_we = 1'b0;
    coef_m[3] = -5;
    run_txn(32767, 0, 1'b1, got);
    for (int i = 0; i < NTAPS; i++) run_txn(0, 0, 1'b0, got);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
